// File: rtl/imm_decode_stage.sv
// Decode front end: opcode -> immediate select/extend, buffered in a 2-entry skid FIFO.
// Optional IMM_ILLEGAL_TRAP_EN adds out_illegal for unmapped opcodes.
module imm_decode_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [1:0]  out_sext_type,
`ifdef IMM_ILLEGAL_TRAP_EN
  output logic        out_illegal,
`endif
  output logic        out_uses_imm
);

  localparam logic [1:0] FULL = DEPTH[1:0];

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_R   = 7'b0110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [1:0]  sext_type;
`ifdef IMM_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic        uses_imm;
  } entry_t;

  entry_t     dec;
  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_nx;
  logic       push;
  logic       pop;
  logic [6:0] opc;
  logic [31:0] i;

  assign i   = in_instr;
  assign opc = in_instr[6:0];

  always_comb begin
    dec           = '0;
    dec.instr     = in_instr;
    dec.pc        = in_pc;
    dec.uses_imm  = 1'b1;
    unique case (1'b1)
      (opc == OP_IMM), (opc == OP_LD),
      (opc == OP_JLR), (opc == OP_SYS): begin
        dec.imm = {{20{i[31]}}, i[31:20]};
      end
      (opc == OP_ST): begin
        dec.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      (opc == OP_BR): begin
        dec.sext_type = 2'b01;
        dec.imm = {{19{i[31]}}, i[31], i[7],
                   i[30:25], i[11:8], 1'b0};
      end
      (opc == OP_LUI), (opc == OP_AUI): begin
        dec.sext_type = 2'b10;
        dec.imm = {i[31:12], 12'b0};
      end
      (opc == OP_JAL): begin
        dec.sext_type = 2'b11;
        dec.imm = {{11{i[31]}}, i[31], i[19:12],
                   i[20], i[30:21], 1'b0};
      end
      (opc == OP_R): begin
        dec.uses_imm = 1'b0;
      end
      default: begin
        dec.uses_imm = 1'b0;
`ifdef IMM_ILLEGAL_TRAP_EN
        dec.illegal  = 1'b1;
`endif
      end
    endcase
  end

  assign out_valid = (count != 2'd0);
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    count_nx = count;
    if (flush)
      count_nx = 2'd0;
    else if (push && !pop)
      count_nx = count + 2'd1;
    else if (pop && !push)
      count_nx = count - 2'd1;
  end

  // in_ready is registered so there is no ready path from execute back to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      count    <= count_nx;
      in_ready <= (count_nx != FULL);
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
      end
    end
  end

  assign out_instr     = mem[rd_ptr].instr;
  assign out_pc        = mem[rd_ptr].pc;
  assign out_imm       = mem[rd_ptr].imm;
  assign out_sext_type = mem[rd_ptr].sext_type;
  assign out_uses_imm  = mem[rd_ptr].uses_imm;
`ifdef IMM_ILLEGAL_TRAP_EN
  assign out_illegal   = mem[rd_ptr].illegal;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vectors, stall, flush, reset.
// Builds with or without IMM_ILLEGAL_TRAP_EN.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [1:0]  out_sext_type;
  logic        out_uses_imm;
`ifdef IMM_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_imm       (out_imm),
    .out_sext_type (out_sext_type),
`ifdef IMM_ILLEGAL_TRAP_EN
    .out_illegal   (out_illegal),
`endif
    .out_uses_imm  (out_uses_imm)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one instruction with out_ready high; it must be the head one cycle later.
  task automatic push_chk(input string tag,
                          input logic [31:0] ins,
                          input logic [31:0] pc,
                          input logic [31:0] imm,
                          input logic [1:0]  st,
                          input logic        ui,
                          input logic        ill);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    tick();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, ins);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_imm"}, out_imm, imm);
    chk({tag, "_sext"}, {30'b0, out_sext_type}, {30'b0, st});
    chk({tag, "_uses"}, {31'b0, out_uses_imm}, {31'b0, ui});
`ifdef IMM_ILLEGAL_TRAP_EN
    chk({tag, "_ill"}, {31'b0, out_illegal}, {31'b0, ill});
`else
    if (ill) chk({tag, "_noill_uses"}, {31'b0, out_uses_imm}, 32'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);

    rst = 1'b0;
    out_ready = 1'b1;
    push_chk("addi", 32'h00500093, 32'h100, 32'h00000005, 2'b00, 1'b1, 1'b0);
    push_chk("beq",  32'hFE000EE3, 32'h104, 32'hFFFFFFFC, 2'b01, 1'b1, 1'b0);
    push_chk("sw",   32'h00112623, 32'h108, 32'h0000000C, 2'b00, 1'b1, 1'b0);
    push_chk("lui",  32'h123450B7, 32'h10C, 32'h12345000, 2'b10, 1'b1, 1'b0);
    push_chk("jal",  32'h0000006F, 32'h110, 32'h00000000, 2'b11, 1'b1, 1'b0);
    push_chk("ld_neg", 32'hFFC12083, 32'h114, 32'hFFFFFFFC, 2'b00, 1'b1, 1'b0);
    push_chk("sw_neg", 32'hFE112E23, 32'h118, 32'hFFFFFFFC, 2'b00, 1'b1, 1'b0);
    push_chk("jal_neg", 32'hFFDFF06F, 32'h11C, 32'hFFFFFFFC, 2'b11, 1'b1, 1'b0);
    push_chk("add",  32'h002081B3, 32'h120, 32'h00000000, 2'b00, 1'b0, 1'b0);
    push_chk("ill",  32'h0000000B, 32'h124, 32'h00000000, 2'b00, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Stall: only two accepted while out_ready is low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    tick();
    chk("stall_rdy1", {31'b0, in_ready}, 32'd1);
    in_instr = 32'h00200093;
    tick();
    chk("stall_rdy2", {31'b0, in_ready}, 32'd0);
    chk("stall_head", out_instr, 32'h00100093);
    in_instr = 32'h00300093;
    tick();
    chk("stall_hold", out_instr, 32'h00100093);
    chk("stall_hold_imm", out_imm, 32'd1);
    chk("stall_rdy3", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("drain_b", out_instr, 32'h00200093);
    chk("drain_rdy", {31'b0, in_ready}, 32'd1);
    tick();
    chk("drain_c", out_instr, 32'h00300093);
    chk("drain_c_imm", out_imm, 32'd3);
    in_valid = 1'b0;
    tick();
    chk("drain_done", {31'b0, out_valid}, 32'd0);

    // Flush from full with an instruction presented.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00400093;
    tick();
    in_instr  = 32'h00500093;
    tick();
    chk("full_rdy", {31'b0, in_ready}, 32'd0);
    flush    = 1'b1;
    in_instr = 32'h00600093;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_rdy", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_stays", {31'b0, out_valid}, 32'd0);

    // Flush at count 1 while in_ready is high: the presented word is dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00700093;
    tick();
    flush    = 1'b1;
    in_instr = 32'h00800093;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush1_valid", {31'b0, out_valid}, 32'd0);
    push_chk("post_flush", 32'h00900093, 32'h200, 32'h00000009, 2'b00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, then push on first edge after release.
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_rdy", {31'b0, in_ready}, 32'd1);
    chk("arst_data", out_instr, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    push_chk("post_rst", 32'h00A00093, 32'h300, 32'h0000000A, 2'b00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
